// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: opcodes, ALU operation codes, control FSM states.
package riscv_pkg;

    localparam int unsigned OPC_W = 7;
    localparam int unsigned ALU_W = 5;

    localparam logic [OPC_W-1:0] OP_REG = 7'b0110011;
    localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPC_W-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPC_W-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPC_W-1:0] OP_B   = 7'b1100011;
    localparam logic [OPC_W-1:0] OP_JAL = 7'b1101111;

    localparam logic [ALU_W-1:0] ALU_ADD  = 5'd0;
    localparam logic [ALU_W-1:0] ALU_SUB  = 5'd1;
    localparam logic [ALU_W-1:0] ALU_AND  = 5'd2;
    localparam logic [ALU_W-1:0] ALU_OR   = 5'd3;
    localparam logic [ALU_W-1:0] ALU_XOR  = 5'd4;
    localparam logic [ALU_W-1:0] ALU_SLL  = 5'd5;
    localparam logic [ALU_W-1:0] ALU_SRL  = 5'd6;
    localparam logic [ALU_W-1:0] ALU_SRA  = 5'd7;
    localparam logic [ALU_W-1:0] ALU_SLT  = 5'd8;
    localparam logic [ALU_W-1:0] ALU_SLTU = 5'd9;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        STALL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode/funct3/funct7 to ALUOp mapping.
module alu_op_decode
    import riscv_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic [ALU_W-1:0] alu_op_c
);

    // Only funct7[5] distinguishes SUB/SRA; the rest of funct7 is don't-care here.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // ALU operation select; loads, stores and jumps use ADD, branches compare with SUB.
    always_comb begin
        alu_op_c = ALU_ADD;
        case (opcode)
            OP_REG, OP_IMM: begin
                case (funct3)
                    3'b000: alu_op_c = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
                    3'b001: alu_op_c = ALU_SLL;
                    3'b010: alu_op_c = ALU_SLT;
                    3'b011: alu_op_c = ALU_SLTU;
                    3'b100: alu_op_c = ALU_XOR;
                    3'b101: alu_op_c = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110: alu_op_c = ALU_OR;
                    default: alu_op_c = ALU_AND;
                endcase
            end
            OP_B:    alu_op_c = ALU_SUB;
            default: alu_op_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline control: ID decode, load-use/branch stall sequencing, delayed BHT/BTB training.
// Optional PIPE_CTRL_PERF_EN adds saturating branch/mispredict/stall-cycle counters.
module pipeline_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned BR_STALL_MAX  = 2,
    parameter int unsigned WARMUP_CYCLES = 1
) (
    input  logic             clk,
    input  logic             start,
    input  logic [OPC_W-1:0] opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             load_stall,
    input  logic [1:0]       br_stall,
    input  logic             ID_PCSrc,
    input  logic             IF_ID_branch_pred,
    output logic             ALUSrc,
    output logic             PCSrcCont,
    output logic             MemWrite,
    output logic             MemRead,
    output logic             MemToReg,
    output logic             RegWrite,
    output logic [ALU_W-1:0] ALUOp,
    output logic             IsStall,
    output logic             bht_update,
    output logic             bht_update_dir,
    output logic             btb_update
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_branches,
    output logic [31:0]      perf_mispredicts,
    output logic [31:0]      perf_stall_cycles
`endif
);

    localparam int unsigned CNT_W = 16;

    pipe_state_e      state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] br_len, hz_len;
    logic             hazard;
    logic             decode_en;
    logic             train_fire;
    logic [ALU_W-1:0] dec_alu_op_c;

    alu_op_decode u_alu_op_decode (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op_c (dec_alu_op_c)
    );

    // Requested stall length: clamped branch length vs. one-cycle load-use, larger wins.
    always_comb begin
        hazard = load_stall || (br_stall != 2'd0);
        br_len = (CNT_W'(br_stall) > CNT_W'(BR_STALL_MAX)) ? CNT_W'(BR_STALL_MAX) : CNT_W'(br_stall);
        hz_len = (load_stall && (br_len < CNT_W'(1))) ? CNT_W'(1) : br_len;
    end

    // State/counter register.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            state <= WARMUP;
            cnt   <= CNT_W'(WARMUP_CYCLES - 1);
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state and stall; the hazard cycle itself is the first stall cycle, so STALL covers len-1.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        IsStall   = 1'b0;
        decode_en = 1'b0;
        case (state)
            WARMUP: begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            RUN: begin
                if (hazard) begin
                    IsStall = 1'b1;
                    if (hz_len > CNT_W'(1)) begin
                        state_nxt = STALL;
                        cnt_nxt   = hz_len - CNT_W'(2);
                    end
                end else begin
                    decode_en = 1'b1;
                end
            end
            STALL: begin
                IsStall = 1'b1;
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - CNT_W'(1);
            end
            default: state_nxt = WARMUP;
        endcase
    end

    // Control word decode; any bubble or unknown opcode yields all zeros with ADD.
    always_comb begin
        ALUSrc     = 1'b0;
        PCSrcCont  = 1'b0;
        MemWrite   = 1'b0;
        MemRead    = 1'b0;
        MemToReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUOp      = ALU_ADD;
        train_fire = 1'b0;
        if (decode_en) begin
            case (opcode)
                OP_REG: begin
                    RegWrite = 1'b1;
                    ALUOp    = dec_alu_op_c;
                end
                OP_IMM: begin
                    ALUSrc   = 1'b1;
                    RegWrite = 1'b1;
                    ALUOp    = dec_alu_op_c;
                end
                OP_LW: begin
                    ALUSrc   = 1'b1;
                    MemRead  = 1'b1;
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
                OP_SW: begin
                    ALUSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                OP_B: begin
                    PCSrcCont  = 1'b1;
                    ALUOp      = ALU_SUB;
                    train_fire = 1'b1;
                end
                OP_JAL: begin
                    PCSrcCont  = 1'b1;
                    RegWrite   = 1'b1;
                    train_fire = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Training strobes one cycle after resolution to line up with the registered update address.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            bht_update     <= 1'b0;
            bht_update_dir <= 1'b0;
            btb_update     <= 1'b0;
        end else begin
            bht_update     <= train_fire;
            bht_update_dir <= train_fire && ID_PCSrc;
            btb_update     <= train_fire && ID_PCSrc;
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    // Saturating performance counters.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            perf_branches     <= '0;
            perf_mispredicts  <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (train_fire && (perf_branches != '1))
                perf_branches <= perf_branches + 32'd1;
            if (train_fire && (ID_PCSrc != IF_ID_branch_pred) && (perf_mispredicts != '1))
                perf_mispredicts <= perf_mispredicts + 32'd1;
            if (IsStall && (perf_stall_cycles != '1))
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`else
    logic unused_pred;
    assign unused_pred = IF_ID_branch_pred;
`endif

endmodule
